// File: rtl/vc32_pkg.sv
// Shared vc32 definitions: memory scheduler state encoding and line/beat geometry.
package vc32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } sched_state_e;

    // Memory moves one nibble per beat, so a line of bytes takes two beats per byte.
    function automatic int nbeats(input int line_length);
        return 32'sd2 * line_length;
    endfunction

endpackage

// File: rtl/cache_mem_sched.sv
// Arbitrates dcache/icache line traffic onto a single nibble-wide memory port:
// optional dirty-line writeback followed by a line fill, then a one-cycle done pulse.
module cache_mem_sched
    import vc32_pkg::*;
#(
    parameter int  PA          = 22,
    parameter int  LINE_LENGTH = 4,
    localparam int TW          = PA - $clog2(LINE_LENGTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_pull,
    input  logic          d_push,
    input  logic [TW-1:0] d_wtag,
    input  logic [TW-1:0] d_rtag,
    input  logic [3:0]    d_dwrite,
    output logic          d_rstrobe,
    output logic          d_wstrobe,
    output logic          d_done,
    input  logic          i_pull,
    input  logic [TW-1:0] i_tag,
    output logic          i_wstrobe,
    output logic          i_done,
    output logic          mem_start,
    output logic          mem_we,
    output logic [TW-1:0] mem_addr,
    output logic [3:0]    mem_dout,
    input  logic [3:0]    mem_din,
    input  logic          mem_ready
);

    localparam int            NBEATS    = nbeats(LINE_LENGTH);
    localparam int            BW        = (NBEATS > 32'sd1) ? $clog2(NBEATS) : 32'sd1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 32'sd1);
    localparam logic [BW-1:0] ONE_BEAT  = BW'(32'sd1);

    sched_state_e  r_state;
    sched_state_e  w_state_nxt;
    logic [BW-1:0] r_beat;
    logic [BW-1:0] w_beat_nxt;
    logic          r_gnt_i;      // owner of the current transaction: 1 = icache
    logic          r_last_i;     // last completed grant went to icache
    logic          w_gnt_d;
    logic          w_gnt_i;
    logic          w_last_beat;
    logic          w_wb_to_fill;
    logic          w_start_nxt;
    logic [TW-1:0] w_addr_nxt;
    logic          r_mem_start;
    logic          r_mem_we;
    logic          r_d_done;
    logic          r_i_done;
    logic [TW-1:0] r_mem_addr;
    logic          w_unused_din;

    // Fill data goes straight from memory to the caches; the scheduler only sequences it.
    assign w_unused_din = ^mem_din;

    assign w_last_beat  = mem_ready && (r_beat == LAST_BEAT);
    assign w_wb_to_fill = (r_state == ST_WB) && w_last_beat;
    assign w_start_nxt  = w_gnt_d || w_gnt_i || w_wb_to_fill;

    // Round-robin arbiter, evaluated only while idle; a tie goes to whoever was not granted last.
    always_comb begin
        w_gnt_d = 1'b0;
        w_gnt_i = 1'b0;
        if (r_state == ST_IDLE) begin
            if (d_pull && i_pull) begin
                w_gnt_d = r_last_i;
                w_gnt_i = !r_last_i;
            end else begin
                w_gnt_d = d_pull;
                w_gnt_i = i_pull;
            end
        end else begin
            w_gnt_d = 1'b0;
            w_gnt_i = 1'b0;
        end
    end

    // Next-state and beat counter: beats advance only when memory takes or gives a nibble.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_d) begin
                    w_state_nxt = d_push ? ST_WB : ST_FILL;
                    w_beat_nxt  = '0;
                end else if (w_gnt_i) begin
                    w_state_nxt = ST_FILL;
                    w_beat_nxt  = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WB: begin
                if (w_last_beat) begin
                    w_state_nxt = ST_FILL;
                    w_beat_nxt  = '0;
                end else if (mem_ready) begin
                    w_beat_nxt = r_beat + ONE_BEAT;
                end else begin
                    w_beat_nxt = r_beat;
                end
            end
            ST_FILL: begin
                if (w_last_beat) begin
                    w_state_nxt = ST_DONE;
                    w_beat_nxt  = '0;
                end else if (mem_ready) begin
                    w_beat_nxt = r_beat + ONE_BEAT;
                end else begin
                    w_beat_nxt = r_beat;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_beat_nxt  = '0;
            end
        endcase
    end

    // Line address is captured at grant and again when a writeback hands over to its fill.
    always_comb begin
        w_addr_nxt = r_mem_addr;
        if (w_gnt_d) begin
            w_addr_nxt = d_push ? d_wtag : d_rtag;
        end else if (w_gnt_i) begin
            w_addr_nxt = i_tag;
        end else if (w_wb_to_fill) begin
            w_addr_nxt = d_rtag;
        end else begin
            w_addr_nxt = r_mem_addr;
        end
    end

    // State, ownership and registered memory/done outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_beat      <= '0;
            r_gnt_i     <= 1'b0;
            r_last_i    <= 1'b1;
            r_mem_start <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_d_done    <= 1'b0;
            r_i_done    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat      <= w_beat_nxt;
            r_mem_start <= w_start_nxt;
            r_mem_we    <= (w_state_nxt == ST_WB);
            r_mem_addr  <= w_addr_nxt;
            r_d_done    <= (w_state_nxt == ST_DONE) && !r_gnt_i;
            r_i_done    <= (w_state_nxt == ST_DONE) && r_gnt_i;
            if (w_gnt_d) begin
                r_gnt_i <= 1'b0;
            end else if (w_gnt_i) begin
                r_gnt_i <= 1'b1;
            end else begin
                r_gnt_i <= r_gnt_i;
            end
            if (r_state == ST_DONE) begin
                r_last_i <= r_gnt_i;
            end else begin
                r_last_i <= r_last_i;
            end
        end
    end

    assign mem_start = r_mem_start;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign d_done    = r_d_done;
    assign i_done    = r_i_done;

    // Strobes follow mem_ready within the phase so a stalled beat never strobes.
    assign d_rstrobe = (r_state == ST_WB) && mem_ready;
    assign d_wstrobe = (r_state == ST_FILL) && !r_gnt_i && mem_ready;
    assign i_wstrobe = (r_state == ST_FILL) && r_gnt_i && mem_ready;
    assign mem_dout  = (r_state == ST_WB) ? d_dwrite : 4'h0;

endmodule

// File: tb/tb_cache_mem_sched.sv
// Directed bench for cache_mem_sched: a table of single transactions plus hand-written
// sequences for arbitration ties, non-preemption, d_push without d_pull and reset mid-writeback.
module tb_cache_mem_sched;

    localparam int PA = 22;
    localparam int LL = 4;
    localparam int TW = PA - 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          d_pull = 1'b0, d_push = 1'b0, i_pull = 1'b0;
    logic [TW-1:0] d_wtag = '0, d_rtag = '0, i_tag = '0;
    logic [3:0]    d_dwrite = 4'h0, mem_din = 4'h0;
    logic          mem_ready = 1'b1;
    logic          d_rstrobe, d_wstrobe, d_done, i_wstrobe, i_done, mem_start, mem_we;
    logic [TW-1:0] mem_addr;
    logic [3:0]    mem_dout;

    int checks = 0;
    int errors = 0;

    cache_mem_sched #(.PA(PA), .LINE_LENGTH(LL)) dut (
        .clk(clk), .reset(reset),
        .d_pull(d_pull), .d_push(d_push), .d_wtag(d_wtag), .d_rtag(d_rtag),
        .d_dwrite(d_dwrite), .d_rstrobe(d_rstrobe), .d_wstrobe(d_wstrobe), .d_done(d_done),
        .i_pull(i_pull), .i_tag(i_tag), .i_wstrobe(i_wstrobe), .i_done(i_done),
        .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .mem_din(mem_din), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          dp, push, ip;
        logic [TW-1:0] wt, rt, it;
        int            rdy_mode;     // 0: ready always, 1: ready on even cycles
        int            exp_starts;
        logic [TW-1:0] exp_addr1, exp_addr_done;
        logic          exp_we1;
        int            exp_rstr, exp_dwstr, exp_iwstr, exp_done_cyc;
        logic          exp_dd, exp_id;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({d_rstrobe, d_wstrobe, d_done, i_wstrobe, i_done, mem_start, mem_we, mem_addr, mem_dout});
    endfunction

    function automatic logic [63:0] ctl_outs();
        return 64'({d_rstrobe, d_wstrobe, d_done, i_wstrobe, i_done, mem_start, mem_we, mem_dout});
    endfunction

    // One cycle: drive inputs mid-cycle, then sample what the DUT shows in that cycle.
    task automatic tick(input logic dp, input logic push, input logic ip, input logic rdy);
        @(negedge clk);
        d_pull    = dp;
        d_push    = push;
        i_pull    = ip;
        mem_ready = rdy;
        d_dwrite  = 4'($urandom_range(0, 15));
        mem_din   = 4'($urandom_range(0, 15));
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int            n_start = 0, n_r = 0, n_dw = 0, n_iw = 0, bad = 0, done_cyc = -1;
        logic [TW-1:0] a1 = '0, ad = '0;
        logic          we1 = 1'b0, dd = 1'b0, id = 1'b0;
        d_wtag = v.wt;
        d_rtag = v.rt;
        i_tag  = v.it;
        for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
            tick(v.dp, v.push, v.ip, (v.rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 0));
            if (mem_start) begin
                n_start++;
                if (n_start == 1) begin
                    a1  = mem_addr;
                    we1 = mem_we;
                end
            end
            n_r  += int'(d_rstrobe);
            n_dw += int'(d_wstrobe);
            n_iw += int'(i_wstrobe);
            if ((d_rstrobe || d_wstrobe || i_wstrobe) && !mem_ready) bad++;
            if (d_rstrobe && !mem_we) bad++;
            if ((d_wstrobe || i_wstrobe) && mem_we) bad++;
            if (d_wstrobe && i_wstrobe) bad++;
            if (mem_dout !== (mem_we ? d_dwrite : 4'h0)) bad++;
            if (d_done || i_done) begin
                done_cyc = cyc;
                dd = d_done;
                id = i_done;
                ad = mem_addr;
            end
        end
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL v%0d_timeout no done pulse within 60 cycles", idx);
            do_reset();
        end
        check($sformatf("v%0d_starts", idx), 64'(n_start), 64'(v.exp_starts));
        check($sformatf("v%0d_addr_first", idx), 64'(a1), 64'(v.exp_addr1));
        check($sformatf("v%0d_addr_at_done", idx), 64'(ad), 64'(v.exp_addr_done));
        check($sformatf("v%0d_we_first", idx), 64'(we1), 64'(v.exp_we1));
        check($sformatf("v%0d_rstrobes", idx), 64'(n_r), 64'(v.exp_rstr));
        check($sformatf("v%0d_d_wstrobes", idx), 64'(n_dw), 64'(v.exp_dwstr));
        check($sformatf("v%0d_i_wstrobes", idx), 64'(n_iw), 64'(v.exp_iwstr));
        check($sformatf("v%0d_done_cycle", idx), 64'(done_cyc), 64'(v.exp_done_cyc));
        check($sformatf("v%0d_done_which", idx), 64'({dd, id}), 64'({v.exp_dd, v.exp_id}));
        check($sformatf("v%0d_protocol_errs", idx), 64'(bad), 64'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check($sformatf("v%0d_idle_after_done", idx), ctl_outs(), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int            dcyc[3], ccyc[3], nd, ns, n_iw_early, d_dc, i_dc, n_dw, n_iw, n_r, hits;
        logic          dwhich[3];
        logic [TW-1:0] saddr[3];

        vecs[0] = '{1'b1, 1'b0, 1'b0, 20'h00000, 20'h01234, 20'h00000, 0, 1, 20'h01234, 20'h01234, 1'b0, 0, 8, 0, 10, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 20'h00AAA, 20'h00BBB, 20'h00000, 0, 2, 20'h00AAA, 20'h00BBB, 1'b1, 8, 8, 0, 18, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 20'h00000, 20'h00000, 20'h05555, 0, 1, 20'h05555, 20'h05555, 1'b0, 0, 0, 8, 10, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 20'h00000, 20'h0F0F0, 20'h00000, 1, 1, 20'h0F0F0, 20'h0F0F0, 1'b0, 0, 8, 0, 17, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 20'h11111, 20'h22222, 20'h00000, 1, 2, 20'h11111, 20'h22222, 1'b1, 8, 8, 0, 33, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 20'h0ABCD, 20'h01234, 20'hFFFFF, 0, 1, 20'hFFFFF, 20'hFFFFF, 1'b0, 0, 0, 8, 10, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 20'hFFFFF, 20'h00000, 20'h00000, 0, 1, 20'h00000, 20'h00000, 1'b0, 0, 8, 0, 10, 1'b1, 1'b0};

        // Reset dominates even with every request asserted.
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        check("reset_outs_a", all_outs(), 64'd0);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        check("reset_outs_b", all_outs(), 64'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("idle_after_reset", all_outs(), 64'd0);

        for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

        // Tie from reset: dcache, then icache, then dcache again.
        do_reset();
        d_rtag = 20'h0DDDD;
        i_tag  = 20'h0EEEE;
        nd = 0;
        ns = 0;
        for (int cyc = 1; cyc <= 60 && nd < 3; cyc++) begin
            tick(1'b1, 1'b0, 1'b1, 1'b1);
            if (mem_start && ns < 3) begin
                ccyc[ns]  = cyc;
                saddr[ns] = mem_addr;
                ns++;
            end
            if (d_done || i_done) begin
                dcyc[nd]   = cyc;
                dwhich[nd] = d_done;
                nd++;
            end
        end
        check("tie_done_count", 64'(nd), 64'd3);
        check("tie_start_count", 64'(ns), 64'd3);
        if (nd == 3 && ns == 3) begin
            check("tie_order", 64'({dwhich[0], dwhich[1], dwhich[2]}), 64'(3'b101));
            check("tie_done_cycles", 64'({16'(dcyc[0]), 16'(dcyc[1]), 16'(dcyc[2])}), {16'd0, 16'd10, 16'd20, 16'd30});
            check("tie_start_cycles", 64'({16'(ccyc[0]), 16'(ccyc[1]), 16'(ccyc[2])}), {16'd0, 16'd2, 16'd12, 16'd22});
            check("tie_addr_0", 64'(saddr[0]), 64'(20'h0DDDD));
            check("tie_addr_1", 64'(saddr[1]), 64'(20'h0EEEE));
            check("tie_addr_2", 64'(saddr[2]), 64'(20'h0DDDD));
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // No preemption: icache asks mid-transfer and is served only after the dcache done.
        d_rtag = 20'h03333;
        i_tag  = 20'h04444;
        d_dc = -1; i_dc = -1; n_iw_early = 0; n_dw = 0; n_iw = 0;
        for (int cyc = 1; cyc <= 40 && i_dc < 0; cyc++) begin
            tick(cyc <= 2, 1'b0, cyc >= 3, 1'b1);
            n_dw += int'(d_wstrobe);
            n_iw += int'(i_wstrobe);
            if (i_wstrobe && d_dc < 0) n_iw_early++;
            if (d_done) d_dc = cyc;
            if (i_done) i_dc = cyc;
        end
        check("nopreempt_d_done", 64'(d_dc), 64'd10);
        check("nopreempt_i_done", 64'(i_dc), 64'd20);
        check("nopreempt_i_early", 64'(n_iw_early), 64'd0);
        check("nopreempt_strobes", 64'({16'(n_dw), 16'(n_iw)}), {32'd0, 16'd8, 16'd8});
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // d_push without d_pull must not start anything.
        hits = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b1);
            if (ctl_outs() != 64'd0) hits++;
        end
        check("push_alone_idle", 64'(hits), 64'd0);

        // Reset at writeback beat 3 aborts with no done pulse.
        d_wtag = 20'h0ABCD;
        d_rtag = 20'h01111;
        n_r = 0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b1);
            n_r += int'(d_rstrobe);
        end
        check("midwb_rstrobes", 64'(n_r), 64'd4);
        check("midwb_active", 64'({mem_we, d_rstrobe, mem_addr}), 64'({2'b11, 20'h0ABCD}));
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("midwb_reset_outs", all_outs(), 64'd0);
        reset = 1'b0;
        hits = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            if (d_done || i_done || mem_start || mem_we) hits++;
        end
        check("midwb_no_done", 64'(hits), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
